div_driver: RTL and testbench

Self-checking stimulus master for the Q10.10 fractional divider. It generates pseudo-random dividend/divisor pairs and drives them over the divider's `in_valid`/`in_data_1`/`in_data_2` input handshake. It then collects each quotient from `out_valid`/`out_data`, verifies it using multiplication only, and accumulates pass/fail counts. It sits beside the divider in the FPGA/emulation top level and replaces the software pattern generator.

---
 rtl/div_driver.sv | 203 ++++++++++++++++++++
 tb/tb_div_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_driver.sv
// Stimulus master and multiply-only checker for the Q10.10 fractional divider.
// Optional watchdog on the result wait is enabled by defining DIV_DRV_TIMEOUT_EN.
module div_driver #(
  parameter int unsigned NUM_VECTORS  = 64,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned VALID_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dut_in_valid,
  output logic [9:0]  dut_in_data_1,
  output logic [2:0]  dut_in_data_2,
  input  logic        dut_out_valid,
  input  logic [19:0] dut_out_data,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        err_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0]  LP_VC_LAST = 4'(VALID_CYCLES - 1);
  localparam logic [15:0] LP_NVEC    = 16'(NUM_VECTORS);
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

`ifdef DIV_DRV_TIMEOUT_EN
  localparam bit LP_WDOG_EN = 1'b1;
`else
  localparam bit LP_WDOG_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_lfsr;
  logic [9:0]  r_d1;
  logic [2:0]  r_d2;
  logic [19:0] r_q_p0;
  logic        r_ov_d;
  logic [15:0] r_vec;
  logic [15:0] r_pass;
  logic [15:0] r_fail;
  logic        r_err;
  logic [3:0]  r_vcnt;
  logic [15:0] r_wdog;
  logic        w_rise;
  logic        w_pass;
  logic        w_timeout;
  logic        w_last_vec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [2:0] divisor_of(input logic [2:0] v);
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

  // Q is the floor quotient iff Q*d <= N < (Q+1)*d; no divider needed.
  function automatic logic quotient_ok(input logic [19:0] q, input logic [9:0] dd,
                                       input logic [2:0] dv);
    logic [22:0] n;
    logic [22:0] lo;
    logic [22:0] hi;
    n  = {3'b000, dd, 10'b0};
    lo = {3'b000, q} * {20'b0, dv};
    hi = ({3'b000, q} + 23'd1) * {20'b0, dv};
    return (lo <= n) && (hi > n);
  endfunction

  assign w_rise     = dut_out_valid & ~r_ov_d;
  assign w_pass     = quotient_ok(r_q_p0, r_d1, r_d2);
  assign w_last_vec = (r_vec == LP_NVEC);
  assign w_timeout  = LP_WDOG_EN && (r_state == S_WAIT) && (r_wdog == LP_TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    dut_in_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        busy         = 1'b1;
        dut_in_valid = 1'b1;
        if (r_vcnt == LP_VC_LAST) w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_rise)         w_next = S_CHECK;
        else if (w_timeout) w_next = S_DONE;
      end
      S_CHECK: begin
        busy   = 1'b1;
        w_next = S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (!dut_out_valid) w_next = w_last_vec ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_DRIVE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stage p0: quotient capture on the first high cycle of the result strobe.
  always_ff @(posedge clk) begin
    if (r_state == S_WAIT && w_rise) r_q_p0 <= dut_out_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
      r_d1   <= 10'd0;
      r_d2   <= 3'd0;
      r_ov_d <= 1'b0;
      r_vec  <= 16'd0;
      r_pass <= 16'd0;
      r_fail <= 16'd0;
      r_err  <= 1'b0;
      r_vcnt <= 4'd0;
    end else begin
      r_ov_d <= dut_out_valid;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr <= SEED;
            r_d1   <= SEED[9:0];
            r_d2   <= divisor_of(SEED[12:10]);
            r_vec  <= 16'd0;
            r_pass <= 16'd0;
            r_fail <= 16'd0;
            r_err  <= 1'b0;
            r_vcnt <= 4'd0;
          end
        end
        S_DRIVE: r_vcnt <= r_vcnt + 4'd1;
        S_WAIT: begin
          if (!w_rise && w_timeout) begin
            r_fail <= sat_inc(r_fail);
            r_err  <= 1'b1;
          end
        end
        // Stage p1: verdict on the captured quotient, then advance the sequence.
        S_CHECK: begin
          if (w_pass) begin
            r_pass <= sat_inc(r_pass);
          end else begin
            r_fail <= sat_inc(r_fail);
            r_err  <= 1'b1;
          end
          r_lfsr <= lfsr_step(r_lfsr);
          r_vec  <= r_vec + 16'd1;
        end
        S_GAP: begin
          if (!dut_out_valid && !w_last_vec) begin
            r_d1   <= r_lfsr[9:0];
            r_d2   <= divisor_of(r_lfsr[12:10]);
            r_vcnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Watchdog is held at zero outside WAIT and whenever the feature is off.
  always_ff @(posedge clk) begin
    if (!rst_n || !LP_WDOG_EN || r_state != S_WAIT) r_wdog <= 16'd0;
    else                                            r_wdog <= r_wdog + 16'd1;
  end

  assign dut_in_data_1 = r_d1;
  assign dut_in_data_2 = r_d2;
  assign pass_cnt      = r_pass;
  assign fail_cnt      = r_fail;
  assign err_flag      = r_err;

endmodule

// File: tb/tb_div_driver.sv
// Directed bench for div_driver: golden/corrupting/silent responders on one
// instance, a VALID_CYCLES=3 instance with a golden responder alongside.
module tb_div_driver;

  logic        clk;
  logic        rst_n, start, busy, done, in_valid, out_valid, err_flag;
  logic [9:0]  in_d1;
  logic [2:0]  in_d2;
  logic [19:0] out_data;
  logic [15:0] pass_cnt, fail_cnt;

  logic        rst_n_b, start_b, busy_b, done_b, in_valid_b, out_valid_b, err_b;
  logic [9:0]  in_d1_b;
  logic [2:0]  in_d2_b;
  logic [19:0] out_data_b;
  logic [15:0] pass_b, fail_b;

  int          n_chk = 0;
  int          n_err = 0;
  int          mode = 0;       // 0 golden, 1 corrupt first result, 2 silent
  int          resp_idx = 0;
  int          pulses = 0;
  logic [19:0] q_first = 20'd0;
  bit          b_finished = 0;

  div_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .dut_in_valid(in_valid), .dut_in_data_1(in_d1), .dut_in_data_2(in_d2),
    .dut_out_valid(out_valid), .dut_out_data(out_data),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag)
  );

  div_driver #(.VALID_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b),
    .dut_in_valid(in_valid_b), .dut_in_data_1(in_d1_b), .dut_in_data_2(in_d2_b),
    .dut_out_valid(out_valid_b), .dut_out_data(out_data_b),
    .pass_cnt(pass_b), .fail_cnt(fail_b), .err_flag(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq(tag, done, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_valid"}, in_valid, 0);
    chk_eq({tag, "_d1"}, in_d1, 0);
    chk_eq({tag, "_d2"}, in_d2, 0);
    chk_eq({tag, "_pass"}, pass_cnt, 0);
    chk_eq({tag, "_fail"}, fail_cnt, 0);
    chk_eq({tag, "_err"}, err_flag, 0);
  endtask

  // Rising edges of the instance-A input strobe.
  initial begin : mon_a
    logic pv;
    pv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (in_valid && !pv) pulses++;
      pv = in_valid;
    end
  end

  // Instance-A divider stand-in: answers a few cycles after in_valid falls.
  initial begin : resp_a
    logic        pv;
    logic [19:0] q;
    pv = 1'b0;
    out_valid = 1'b0;
    out_data = 20'd0;
    forever begin
      @(posedge clk); #1;
      if (pv && !in_valid && mode != 2 && in_d2 != 3'd0) begin
        q = 20'(({10'b0, in_d1} << 10) / {17'b0, in_d2});
        if (resp_idx == 0) q_first = q;
        if (mode == 1 && resp_idx == 0) q = q + 20'd1;
        resp_idx++;
        repeat (3) begin @(posedge clk); #1; end
        out_data = q;
        out_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_valid = 1'b0;
      end
      pv = in_valid;
    end
  end

  // Instance-B stand-in: also checks strobe width and operand stability.
  initial begin : resp_b
    logic        pv;
    int          w;
    logic [9:0]  h1;
    logic [2:0]  h2;
    logic [19:0] q;
    pv = 1'b0; w = 0; h1 = 10'd0; h2 = 3'd0;
    out_valid_b = 1'b0;
    out_data_b = 20'd0;
    forever begin
      @(posedge clk); #1;
      if (in_valid_b && !pv) begin
        w = 1; h1 = in_d1_b; h2 = in_d2_b;
      end else if (in_valid_b) begin
        w++;
        chk_eq("b_hold_drive", {in_d1_b, in_d2_b}, {h1, h2});
      end else if (pv && h2 != 3'd0) begin
        chk_eq("b_width", w, 3);
        q = 20'(({10'b0, h1} << 10) / {17'b0, h2});
        repeat (3) begin @(posedge clk); #1; end
        chk_eq("b_hold_wait", {in_d1_b, in_d2_b}, {h1, h2});
        out_data_b = q;
        out_valid_b = 1'b1;
        @(posedge clk); #1;
        chk_eq("b_hold_check", {in_d1_b, in_d2_b}, {h1, h2});
        @(posedge clk); #1;
        out_valid_b = 1'b0;
      end
      pv = in_valid_b;
    end
  end

  initial begin : ctl_b
    int n;
    rst_n_b = 1'b0;
    start_b = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n_b = 1'b1;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("b_done", done_b, 1);
    chk_eq("b_pass", pass_b, 64);
    chk_eq("b_fail", fail_b, 0);
    chk_eq("b_err", err_b, 0);
    b_finished = 1;
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Golden run; first vector from the unstepped seed 0xACE1.
    mode = 0; resp_idx = 0;
    pulse_start();
    chk_eq("first_busy", busy, 1);
    chk_eq("first_valid", in_valid, 1);
    chk_eq("first_d1", in_d1, 225);
    chk_eq("first_d2", in_d2, 3);
    @(posedge clk); #1;
    chk_eq("valid_width1", in_valid, 0);
    wait_done(3000, "run1_done");
    chk_eq("run1_pass", pass_cnt, 64);
    chk_eq("run1_fail", fail_cnt, 0);
    chk_eq("run1_err", err_flag, 0);
    chk_eq("run1_busy", busy, 0);
    chk_eq("first_quot", q_first, 20'h12C00);

    // One wrong quotient (0x12C01) on the first vector.
    mode = 1; resp_idx = 0;
    pulse_start();
    chk_eq("run2_clr_pass", pass_cnt, 0);
    chk_eq("run2_clr_done", done, 0);
    wait_done(3000, "run2_done");
    chk_eq("run2_pass", pass_cnt, 63);
    chk_eq("run2_fail", fail_cnt, 1);
    chk_eq("run2_err", err_flag, 1);

`ifdef DIV_DRV_TIMEOUT_EN
    // Silent responder: watchdog aborts 64 cycles after WAIT entry.
    mode = 2; pulses = 0;
    pulse_start();
    n = 0;
    while (in_valid !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk_eq("to_cycles", n, 64);
    chk_eq("to_fail", fail_cnt, 1);
    chk_eq("to_pass", pass_cnt, 0);
    chk_eq("to_err", err_flag, 1);
    repeat (20) @(posedge clk);
    #1;
    chk_eq("to_pulses", pulses, 1);
    chk_eq("to_done_hold", done, 1);
`endif

    // Mid-run restart is ignored; reset in WAIT discards the run.
    mode = 2; pulses = 0;
    pulse_start();
    n = 0;
    while (in_valid !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
`ifdef DIV_DRV_TIMEOUT_EN
    repeat (3) @(posedge clk);
`else
    repeat (100) @(posedge clk);
`endif
    #1;
    chk_eq("wait_busy", busy, 1);
    chk_eq("wait_done", done, 0);
    pulse_start();
    chk_eq("restart_valid", in_valid, 0);
    chk_eq("restart_busy", busy, 1);
    @(posedge clk); #1;
    chk_eq("restart_pulses", pulses, 1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("idle_busy", busy, 0);
    mode = 0; resp_idx = 0;
    pulse_start();
    chk_eq("rerun_d1", in_d1, 225);
    chk_eq("rerun_d2", in_d2, 3);
    chk_eq("rerun_valid", in_valid, 1);
    wait_done(3000, "rerun_done");
    chk_eq("rerun_pass", pass_cnt, 64);
    chk_eq("rerun_fail", fail_cnt, 0);

    n = 0;
    while (!b_finished && n < 30000) begin @(posedge clk); n++; end
    chk_eq("b_finished", b_finished, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
